// File: rtl/det_hit_monitor.sv
// det_hit_monitor: registers the Mealy/Moore hit lines, counts their rising edges in BCD and
// checks that each Mealy hit is followed by a Moore hit LAG cycles later. Macro HIT_STRETCH_EN stretches Hit_led.
module det_hit_monitor #(
    parameter int LAG         = 1,
    parameter int STRETCH_CYC = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Clr,
    input  logic       Mealy_hit,
    input  logic       Moore_hit,
    output logic [7:0] Mealy_cnt,
    output logic [7:0] Moore_cnt,
    output logic       Mismatch,
    output logic       Ovf,
    output logic       Hit_led
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [2:0] LAG_LAST = 3'(LAG - 1);
    localparam logic [2:0] LAG_END  = 3'(LAG);

    if (LAG < 1 || LAG > 7) begin : g_bad_lag
        $error("det_hit_monitor: LAG must be 1..7");
    end
    if (STRETCH_CYC < 1 || STRETCH_CYC > 255) begin : g_bad_stretch
        $error("det_hit_monitor: STRETCH_CYC must be 1..255");
    end

    logic   mealy_q1, mealy_q2;
    logic   moore_q1, moore_q2;
    logic   mealy_edge, moore_edge;
    logic   any_edge;
    state_t state_q, state_d;
    logic [2:0] lc_q, lc_d;
    logic   mismatch_set;
    logic [8:0] mealy_next, moore_next;

    // Mealy_hit is combinational upstream, so both lines pass through two flops before edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mealy_q1 <= 1'b0;
            mealy_q2 <= 1'b0;
            moore_q1 <= 1'b0;
            moore_q2 <= 1'b0;
        end else begin
            mealy_q1 <= Mealy_hit;
            mealy_q2 <= mealy_q1;
            moore_q1 <= Moore_hit;
            moore_q2 <= moore_q1;
        end
    end

    assign mealy_edge = mealy_q1 & ~mealy_q2;
    assign moore_edge = moore_q1 & ~moore_q2;
    assign any_edge   = mealy_edge | moore_edge;

    // Returns {wrap, tens, units}; a digit at or above 9 rolls over, so a non-BCD value can never persist.
    function automatic logic [8:0] bcd_step(input logic [7:0] value);
        logic [3:0] tens;
        logic [3:0] units;
        logic       wrap;
        tens  = value[7:4];
        units = value[3:0];
        wrap  = 1'b0;
        if (units >= 4'd9) begin
            units = 4'd0;
            if (tens >= 4'd9) begin
                tens = 4'd0;
                wrap = 1'b1;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            units = units + 4'd1;
        end
        return {wrap, tens, units};
    endfunction

    assign mealy_next = bcd_step(Mealy_cnt);
    assign moore_next = bcd_step(Moore_cnt);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Mealy_cnt <= 8'h00;
            Moore_cnt <= 8'h00;
            Ovf       <= 1'b0;
        end else if (Clr) begin
            Mealy_cnt <= 8'h00;
            Moore_cnt <= 8'h00;
            Ovf       <= 1'b0;
        end else begin
            if (mealy_edge) begin
                Mealy_cnt <= mealy_next[7:0];
            end
            if (moore_edge) begin
                Moore_cnt <= moore_next[7:0];
            end
            if ((mealy_edge && mealy_next[8]) || (moore_edge && moore_next[8])) begin
                Ovf <= 1'b1;
            end
        end
    end

    // Only one pending Mealy hit is tracked; lc counts cycles spent waiting for its Moore partner.
    always_comb begin
        state_d      = state_q;
        lc_d         = lc_q;
        mismatch_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (moore_edge) begin
                    mismatch_set = 1'b1;
                end
                if (mealy_edge) begin
                    state_d = S_WAIT;
                    lc_d    = 3'd0;
                end
            end
            S_WAIT: begin
                if (moore_edge) begin
                    if (lc_q != LAG_LAST) begin
                        mismatch_set = 1'b1;
                    end
                    state_d = mealy_edge ? S_WAIT : S_IDLE;
                    lc_d    = 3'd0;
                end else if (mealy_edge) begin
                    mismatch_set = 1'b1;
                    lc_d         = 3'd0;
                end else if ((lc_q + 3'd1) == LAG_END) begin
                    mismatch_set = 1'b1;
                    state_d      = S_IDLE;
                    lc_d         = 3'd0;
                end else begin
                    lc_d = lc_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                lc_d    = 3'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            lc_q     <= 3'd0;
            Mismatch <= 1'b0;
        end else if (Clr) begin
            state_q  <= S_IDLE;
            lc_q     <= 3'd0;
            Mismatch <= 1'b0;
        end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
            if (mismatch_set) begin
                Mismatch <= 1'b1;
            end
        end
    end

`ifdef HIT_STRETCH_EN
    localparam logic [7:0] STRETCH_LOAD = 8'(STRETCH_CYC);

    logic [7:0] stretch_q;

    // Every edge reloads the on-time, so back-to-back hits extend the LED rather than restarting a gap.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stretch_q <= 8'd0;
        end else if (Clr) begin
            stretch_q <= 8'd0;
        end else if (any_edge) begin
            stretch_q <= STRETCH_LOAD;
        end else if (stretch_q != 8'd0) begin
            stretch_q <= stretch_q - 8'd1;
        end
    end

    assign Hit_led = (stretch_q != 8'd0);
`else
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Hit_led <= 1'b0;
        end else if (Clr) begin
            Hit_led <= 1'b0;
        end else begin
            Hit_led <= any_edge;
        end
    end
`endif

endmodule

// File: tb/tb_det_hit_monitor.sv
// Directed testbench for det_hit_monitor: a LAG=1 instance for counting/reset/Clr/LED checks and
// a LAG=2 instance for early-hit and coincident re-arm pairing checks.
module tb_det_hit_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Clr = 1'b0;
    logic       Mealy_hit = 1'b0;
    logic       Moore_hit = 1'b0;
    logic [7:0] Mealy_cnt, Moore_cnt;
    logic       Mismatch, Ovf, Hit_led;

    logic       lag2_mealy = 1'b0;
    logic       lag2_moore = 1'b0;
    logic [7:0] lag2_mealy_cnt, lag2_moore_cnt;
    logic       lag2_mismatch, lag2_ovf, lag2_hit_led;

    int   passed = 0;
    int   total = 0;
    logic bcd_bad = 1'b0;
    int   led_len;

    det_hit_monitor #(.LAG(1), .STRETCH_CYC(8)) dut (
        .Clk(Clk), .Reset(Reset), .Clr(Clr),
        .Mealy_hit(Mealy_hit), .Moore_hit(Moore_hit),
        .Mealy_cnt(Mealy_cnt), .Moore_cnt(Moore_cnt),
        .Mismatch(Mismatch), .Ovf(Ovf), .Hit_led(Hit_led)
    );

    det_hit_monitor #(.LAG(2), .STRETCH_CYC(8)) dut_lag2 (
        .Clk(Clk), .Reset(Reset), .Clr(Clr),
        .Mealy_hit(lag2_mealy), .Moore_hit(lag2_moore),
        .Mealy_cnt(lag2_mealy_cnt), .Moore_cnt(lag2_moore_cnt),
        .Mismatch(lag2_mismatch), .Ovf(lag2_ovf), .Hit_led(lag2_hit_led)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Moore_cnt[3:0] > 4'd9 || Mealy_cnt[3:0] > 4'd9) begin
            bcd_bad = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // One-cycle high on the chosen lines of the LAG=1 instance, sampled at the next edge.
    task automatic apply_stimulus(input logic mealy, input logic moore);
        Mealy_hit = mealy;
        Moore_hit = moore;
        tick(1);
        Mealy_hit = 1'b0;
        Moore_hit = 1'b0;
    endtask

    task automatic drive_lag2(input logic mealy, input logic moore);
        lag2_mealy = mealy;
        lag2_moore = moore;
        tick(1);
        lag2_mealy = 1'b0;
        lag2_moore = 1'b0;
    endtask

    task automatic pulse_clr();
        Clr = 1'b1;
        tick(1);
        Clr = 1'b0;
    endtask

    initial begin
`ifdef HIT_STRETCH_EN
        led_len = 8;
`else
        led_len = 1;
`endif
        tick(2);
        check_output("reset_mealy_cnt", Mealy_cnt, 8'h00);
        check_output("reset_moore_cnt", Moore_cnt, 8'h00);
        check_output("reset_flags", {5'd0, Mismatch, Ovf, Hit_led}, 8'h00);
        Reset = 1'b1;
        tick(1);

        // Count 37 lone Mealy hits, then pull reset between clock edges.
        for (int i = 0; i < 37; i++) begin
            apply_stimulus(1'b1, 1'b0);
            tick(1);
        end
        check_output("mealy_cnt_37", Mealy_cnt, 8'h37);
        check_output("mismatch_lone_mealy", {7'd0, Mismatch}, 8'h01);
        #2;
        Reset = 1'b0;
        #1;
        check_output("async_reset_cnt", Mealy_cnt, 8'h00);
        check_output("async_reset_mismatch", {7'd0, Mismatch}, 8'h00);
        #1;
        Reset = 1'b1;
        tick(1);
        apply_stimulus(1'b1, 1'b0);
        check_output("latency_not_yet", Mealy_cnt, 8'h00);
        tick(1);
        check_output("latency_two_edges", Mealy_cnt, 8'h01);
        tick(3);
        pulse_clr();

        // An edge arriving in a Clr cycle is discarded.
        Mealy_hit = 1'b1;
        tick(1);
        Mealy_hit = 1'b0;
        Clr = 1'b1;
        tick(1);
        Clr = 1'b0;
        tick(3);
        check_output("clr_discards_edge", Mealy_cnt, 8'h00);
        check_output("clr_discards_mismatch", {7'd0, Mismatch}, 8'h00);

        // Properly paired hits, Moore one cycle after Mealy.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1, 1'b0);
            apply_stimulus(1'b0, 1'b1);
            tick(2);
        end
        check_output("paired_mealy_cnt", Mealy_cnt, 8'h12);
        check_output("paired_moore_cnt", Moore_cnt, 8'h12);
        check_output("paired_no_mismatch", {7'd0, Mismatch}, 8'h00);
        check_output("paired_no_ovf", {7'd0, Ovf}, 8'h00);

        // Hit_led shape after a single hit.
        apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_output($sformatf("hit_led_c%0d", i), {7'd0, Hit_led}, {7'd0, (i < led_len)});
        end
        pulse_clr();
        tick(2);

        // Held Mealy level: one count, then a timeout mismatch.
        Mealy_hit = 1'b1;
        tick(2);
        check_output("held_wait_no_mismatch", {7'd0, Mismatch}, 8'h00);
        check_output("held_count_once", Mealy_cnt, 8'h01);
        tick(1);
        check_output("held_timeout_mismatch", {7'd0, Mismatch}, 8'h01);
        tick(2);
        Mealy_hit = 1'b0;
        tick(3);
        check_output("held_still_one", Mealy_cnt, 8'h01);
        pulse_clr();
        check_output("clr_counts", Mealy_cnt, 8'h00);
        check_output("clr_mismatch", {7'd0, Mismatch}, 8'h00);

        // Moore counter through its wrap.
        bcd_bad = 1'b0;
        for (int i = 0; i < 98; i++) begin
            apply_stimulus(1'b0, 1'b1);
            tick(1);
            if (i == 9) begin
                check_output("moore_carry_10", Moore_cnt, 8'h10);
            end
        end
        check_output("moore_cnt_98", Moore_cnt, 8'h98);
        check_output("ovf_before_wrap", {7'd0, Ovf}, 8'h00);
        apply_stimulus(1'b0, 1'b1);
        tick(1);
        check_output("moore_cnt_99", Moore_cnt, 8'h99);
        apply_stimulus(1'b0, 1'b1);
        tick(1);
        check_output("moore_cnt_wrap", Moore_cnt, 8'h00);
        check_output("ovf_after_wrap", {7'd0, Ovf}, 8'h01);
        check_output("units_always_bcd", {7'd0, bcd_bad}, 8'h00);
        pulse_clr();
        check_output("clr_ovf", {7'd0, Ovf}, 8'h00);

        // Unpaired Moore, then simultaneous edges in IDLE.
        apply_stimulus(1'b0, 1'b1);
        tick(2);
        check_output("lone_moore_mismatch", {7'd0, Mismatch}, 8'h01);
        pulse_clr();
        apply_stimulus(1'b1, 1'b1);
        tick(2);
        check_output("idle_simul_mismatch", {7'd0, Mismatch}, 8'h01);
        check_output("idle_simul_counts", {Mealy_cnt[3:0], Moore_cnt[3:0]}, 8'h11);
        pulse_clr();
        tick(1);

        // LAG=2: exact pairing, coincident resolve plus re-arm, then an early Moore hit.
        drive_lag2(1'b1, 1'b0);
        drive_lag2(1'b0, 1'b0);
        drive_lag2(1'b0, 1'b1);
        tick(3);
        check_output("lag2_match", {7'd0, lag2_mismatch}, 8'h00);
        drive_lag2(1'b1, 1'b0);
        drive_lag2(1'b0, 1'b0);
        drive_lag2(1'b1, 1'b1);
        drive_lag2(1'b0, 1'b0);
        drive_lag2(1'b0, 1'b1);
        tick(3);
        check_output("lag2_rearm_no_mismatch", {7'd0, lag2_mismatch}, 8'h00);
        check_output("lag2_mealy_cnt", lag2_mealy_cnt, 8'h03);
        check_output("lag2_moore_cnt", lag2_moore_cnt, 8'h03);
        drive_lag2(1'b1, 1'b0);
        drive_lag2(1'b0, 1'b1);
        tick(3);
        check_output("lag2_early_mismatch", {7'd0, lag2_mismatch}, 8'h01);
        check_output("lag2_no_ovf", {7'd0, lag2_ovf}, 8'h00);
        check_output("lag2_led_idle", {7'd0, lag2_hit_led}, 8'h00);
        check_output("lag1_untouched", Mealy_cnt, 8'h00);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
